// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: default widths, instruction field map, FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int REG_AW_DEF = 2;

  // Instruction layout, MSB first: sel | rd | ra | rb | use_imm | load_imm | imm
  localparam int IMM_LO       = 0;
  localparam int IMM_HI       = DATA_W_DEF - 1;
  localparam int LOAD_IMM_BIT = DATA_W_DEF;
  localparam int USE_IMM_BIT  = DATA_W_DEF + 1;
  localparam int RB_LO        = DATA_W_DEF + 2;
  localparam int RB_HI        = RB_LO + REG_AW_DEF - 1;
  localparam int RA_LO        = RB_HI + 1;
  localparam int RA_HI        = RA_LO + REG_AW_DEF - 1;
  localparam int RD_LO        = RA_HI + 1;
  localparam int RD_HI        = RD_LO + REG_AW_DEF - 1;
  localparam int SEL_LO       = RD_HI + 1;
  localparam int SEL_HI       = SEL_LO + 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    EXE  = 2'd2,
    WB   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Small operand register file: two combinational read ports, one synchronous write port.
// Latency: reads same cycle, write visible the cycle after i_we.
// Backpressure: none; a write is always accepted.
module alu_seq_regfile #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  localparam int NREG = 2 ** REG_AW;

  logic [NREG-1:0][DATA_W-1:0] r_mem;

  // Storage: cleared on reset, one entry updated per write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one encoded instruction at a time to the external combinational 8-bit ALU and writes the result back.
// Latency: accept at T, operands on the ALU during T+2, result strobe at T+3 (T+2 for load_imm), idle again after WB.
// Backpressure: instr_ready is high only in IDLE; offers made while busy are simply not taken.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int REG_AW  = REG_AW_DEF,
  localparam int INSTR_W = 5 + 3 * REG_AW + 2 + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic               alu_s0,
  output logic               alu_s1,
  output logic               alu_s2,
  output logic               alu_s3,
  output logic               alu_s4,
  input  logic [DATA_W-1:0]  alu_o,
  input  logic               alu_cout,
  output logic               res_valid,
  output logic [DATA_W-1:0]  res_data,
  output logic               res_carry,
  output logic [REG_AW-1:0]  res_rd,
  output logic               busy
);

  seq_state_t         r_state;
  logic [INSTR_W-1:0] r_instr;
  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic [4:0]         r_sel;
  logic               r_carry;
  logic               r_res_valid;
  logic [DATA_W-1:0]  r_res_data;
  logic               r_res_carry;
  logic [REG_AW-1:0]  r_res_rd;

  // Decoded fields of the latched instruction
  logic [4:0]        w_sel;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_ra;
  logic [REG_AW-1:0] w_rb;
  logic              w_use_imm;
  logic              w_load_imm;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rdata_a;
  logic [DATA_W-1:0] w_rdata_b;
  logic              w_we;

  assign w_sel      = r_instr[SEL_HI:SEL_LO];
  assign w_rd       = r_instr[RD_HI:RD_LO];
  assign w_ra       = r_instr[RA_HI:RA_LO];
  assign w_rb       = r_instr[RB_HI:RB_LO];
  assign w_use_imm  = r_instr[USE_IMM_BIT];
  assign w_load_imm = r_instr[LOAD_IMM_BIT];
  assign w_imm      = r_instr[IMM_HI:IMM_LO];

  // Write-back happens at the end of WB from the already-registered result, so an
  // instruction accepted right after sees the new value without any bypass path.
  assign w_we = (r_state == WB);

  alu_seq_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raddr_a (w_ra),
    .i_raddr_b (w_rb),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b),
    .i_we      (w_we),
    .i_waddr   (r_res_rd),
    .i_wdata   (r_res_data)
  );

  // Sequencer FSM with registered ALU drive, result and carry-flag state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_instr     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_sel       <= '0;
      r_carry     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_rd    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= DEC;
          end
        end
        DEC: begin
          if (w_load_imm) begin
            // ALU drive is left untouched; the carry flag passes through unchanged
            r_res_data  <= w_imm;
            r_res_carry <= r_carry;
            r_res_rd    <= w_rd;
            r_res_valid <= 1'b1;
            r_state     <= WB;
          end else begin
            r_alu_a <= w_rdata_a;
            r_alu_b <= w_use_imm ? w_imm : w_rdata_b;
            r_sel   <= w_sel;
            r_state <= EXE;
          end
        end
        EXE: begin
          r_res_data  <= alu_o;
          r_res_carry <= alu_cout;
          r_res_rd    <= w_rd;
          r_res_valid <= 1'b1;
          r_state     <= WB;
        end
        WB: begin
          r_carry     <= r_res_carry;
          r_res_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_s0      = r_sel[0];
  assign alu_s1      = r_sel[1];
  assign alu_s2      = r_sel[2];
  assign alu_s3      = r_sel[3];
  assign alu_s4      = r_sel[4];
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_carry   = r_res_carry;
  assign res_rd      = r_res_rd;

endmodule
